// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA colour-bar path.
//   - Default 640x480@60 Hz timing (pixel clocks / lines per region)
//   - RGB565 colour constants
//   - coord_t: 10-bit screen coordinate / counter type
// No ports; imported by vga_driver and by the pixel-data source.
// -----------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_DISP_DEF  = 640;
  localparam int H_FRONT_DEF = 16;

  // Vertical timing, in lines.
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_DISP_DEF  = 480;
  localparam int V_FRONT_DEF = 10;

  // RGB565 colours.
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;

  // Counters and coordinates are 10 bits wide (up to 1024 positions).
  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_driver.sv
// -----------------------------------------------------------------------------
// vga_driver
// VGA timing generator and pixel sink. Two registered counters (cnt_h, cnt_v)
// walk the sync / back porch / active / front porch regions; every output is a
// combinational decode of those counters.
//
// Pixel coordinates are requested one cycle ahead of the active window so the
// source's registered pixel_data lands exactly on the matching active cycle.
// RGB is forced to black outside the active window.
//
// Ports:
//   vga_clk      in   pixel clock
//   sys_rst_n    in   asynchronous active-low reset
//   pixel_data   in   [15:0] RGB565 from the source, one cycle after its coord
//   pixel_xpos   out  [9:0]  requested column (0 when not requesting)
//   pixel_ypos   out  [9:0]  requested row    (0 when not requesting)
//   vga_hs       out  horizontal sync, active low
//   vga_vs       out  vertical sync, active low
//   vga_rgb      out  [15:0] RGB565 to the DAC
//   frame_start  out  one-cycle pulse at cnt_h = 0, cnt_v = 0
//                     (only when VGA_FRAME_START_EN is defined)
//
// Build option: define VGA_FRAME_START_EN to add the frame_start port.
// -----------------------------------------------------------------------------
module vga_driver
  import vga_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_DISP  = H_DISP_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [15:0] vga_rgb
`ifdef VGA_FRAME_START_EN
  ,
  output logic        frame_start
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  // Both totals must fit the 10-bit counters.
  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_driver: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_driver: V_TOTAL exceeds 1024");
  end

  // Region boundaries pre-sized to the counter width.
  localparam coord_t H_SYNC_END = coord_t'(H_SYNC);
  localparam coord_t H_ACT_BEG  = coord_t'(H_SYNC + H_BACK);
  localparam coord_t H_ACT_END  = coord_t'(H_SYNC + H_BACK + H_DISP);
  localparam coord_t H_REQ_BEG  = coord_t'(H_SYNC + H_BACK - 1);
  localparam coord_t H_REQ_END  = coord_t'(H_SYNC + H_BACK + H_DISP - 1);
  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_SYNC_END = coord_t'(V_SYNC);
  localparam coord_t V_ACT_BEG  = coord_t'(V_SYNC + V_BACK);
  localparam coord_t V_ACT_END  = coord_t'(V_SYNC + V_BACK + V_DISP);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);

  coord_t r_cnt_h;
  coord_t r_cnt_v;
  coord_t w_cnt_h_next;
  coord_t w_cnt_v_next;
  logic   w_line_end;
  logic   w_h_act;
  logic   w_h_req;
  logic   w_v_act;
  logic   w_vga_en;
  logic   w_data_req;

  // ---------------------------------------------------------------------------
  // Counters: cnt_v advances on the last pixel of each line, and both wrap
  // together on the last pixel of the last line.
  // ---------------------------------------------------------------------------
  assign w_line_end = (r_cnt_h == H_LAST);

  always_comb begin
    w_cnt_h_next = r_cnt_h + 10'd1;
    w_cnt_v_next = r_cnt_v;
    if (w_line_end) begin
      w_cnt_h_next = '0;
      if (r_cnt_v == V_LAST) begin
        w_cnt_v_next = '0;
      end else begin
        w_cnt_v_next = r_cnt_v + 10'd1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else begin
      r_cnt_h <= w_cnt_h_next;
      r_cnt_v <= w_cnt_v_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Decodes
  // ---------------------------------------------------------------------------
  assign vga_hs = (r_cnt_h >= H_SYNC_END);
  assign vga_vs = (r_cnt_v >= V_SYNC_END);

  assign w_v_act = (r_cnt_v >= V_ACT_BEG) && (r_cnt_v < V_ACT_END);
  assign w_h_act = (r_cnt_h >= H_ACT_BEG) && (r_cnt_h < H_ACT_END);
  // Request window leads the active window by one pixel clock to cover the
  // source's output register.
  assign w_h_req = (r_cnt_h >= H_REQ_BEG) && (r_cnt_h < H_REQ_END);

  assign w_vga_en   = w_h_act && w_v_act;
  assign w_data_req = w_h_req && w_v_act;

  assign pixel_xpos = w_data_req ? (r_cnt_h - H_REQ_BEG) : '0;
  assign pixel_ypos = w_data_req ? (r_cnt_v - V_ACT_BEG) : '0;

  assign vga_rgb = w_vga_en ? pixel_data : BLACK;

`ifdef VGA_FRAME_START_EN
  // r_frame_start is loaded on the edge that takes the counters to (0,0), so
  // it is high for the whole first cycle of every wrapped frame. The first
  // frame after reset release has no such edge; r_started covers that one
  // cycle, gated by the reset pin so the output stays 0 while in reset.
  logic r_frame_start;
  logic r_started;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_start <= 1'b0;
      r_started     <= 1'b0;
    end else begin
      r_frame_start <= (w_cnt_h_next == '0) && (w_cnt_v_next == '0);
      r_started     <= 1'b1;
    end
  end

  assign frame_start = r_frame_start | (~r_started & sys_rst_n);
`endif

endmodule

// File: tb/tb_vga_driver.sv
// -----------------------------------------------------------------------------
// tb_vga_driver
// Two instances run from the same clock and reset: one with the default
// 640x480 timing and one with a tiny timing so whole frames (frame wrap, last
// active row, frame_start repeats) fit in a short run. A registered pixel
// source per instance returns a random-table value keyed by the requested
// coordinate (or white in constant mode). Expected outputs are computed from
// the cycle count since reset release.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_driver;

  // Small timing: 17 clocks per line, 9 lines per frame.
  localparam int SH_SYNC = 4, SH_BACK = 3, SH_DISP = 8, SH_FRONT = 2;
  localparam int SV_SYNC = 2, SV_BACK = 2, SV_DISP = 4, SV_FRONT = 1;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] rgb;
    logic        fs;
  } exp_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic vga_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // DUT signals
  logic [15:0] pd_b = 16'd0, pd_s = 16'd0;
  logic [9:0]  x_b, y_b, x_s, y_s;
  logic        hs_b, vs_b, hs_s, vs_s;
  logic [15:0] rgb_b, rgb_s;
  logic        fs_b, fs_s;

  vga_driver dut_b (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .pixel_data (pd_b),
    .pixel_xpos (x_b),
    .pixel_ypos (y_b),
    .vga_hs     (hs_b),
    .vga_vs     (vs_b),
    .vga_rgb    (rgb_b)
`ifdef VGA_FRAME_START_EN
    ,
    .frame_start(fs_b)
`endif
  );

  vga_driver #(
    .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_DISP(SH_DISP), .H_FRONT(SH_FRONT),
    .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_DISP(SV_DISP), .V_FRONT(SV_FRONT)
  ) dut_s (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .pixel_data (pd_s),
    .pixel_xpos (x_s),
    .pixel_ypos (y_s),
    .vga_hs     (hs_s),
    .vga_vs     (vs_s),
    .vga_rgb    (rgb_s)
`ifdef VGA_FRAME_START_EN
    ,
    .frame_start(fs_s)
`endif
  );

`ifndef VGA_FRAME_START_EN
  assign fs_b = 1'b0;
  assign fs_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Pixel sources: registered lookup of the requested coordinate.
  // ---------------------------------------------------------------------------
  logic [15:0] tab [256];
  logic        cmode_b = 1'b0, cmode_s = 1'b0;

  function automatic logic [15:0] src_val(input logic cmode, input int x, input int y);
    if (cmode) return 16'hFFFF;
    return tab[(x * 3 + y * 5) & 255];
  endfunction

  always @(posedge vga_clk) begin
    pd_b <= src_val(cmode_b, int'(x_b), int'(y_b));
    pd_s <= src_val(cmode_s, int'(x_s), int'(y_s));
  end

  // ---------------------------------------------------------------------------
  // Reference model: position on screen from elapsed cycles since release.
  // ---------------------------------------------------------------------------
  function automatic exp_t model(input int t, input int hsy, input int hbk,
                                 input int hdi, input int hfr, input int vsy,
                                 input int vbk, input int vdi, input int vfr,
                                 input logic cmode);
    exp_t e;
    int ht, vt, h, v, col, row;
    bit row_act, shown, shown_next;
    ht  = hsy + hbk + hdi + hfr;
    vt  = vsy + vbk + vdi + vfr;
    h   = t % ht;
    v   = (t / ht) % vt;
    col = h - (hsy + hbk);            // displayed column this cycle
    row = v - (vsy + vbk);
    row_act    = (row >= 0) && (row < vdi);
    shown      = row_act && (col >= 0) && (col < hdi);
    // Request is for the column that will be on screen next cycle.
    shown_next = row_act && (col + 1 >= 0) && (col + 1 < hdi);
    e.hs  = (h >= hsy);
    e.vs  = (v >= vsy);
    e.x   = shown_next ? 10'(col + 1) : 10'd0;
    e.y   = shown_next ? 10'(row) : 10'd0;
    e.rgb = shown ? src_val(cmode, col, row) : 16'd0;
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  int t      = 0;
  bit sampling = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d time=%0t)", tag, got, exp, t, $time);
    end
  endtask

  task automatic check_inst(input string pre, input logic hs, input logic vs,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic [15:0] rgb, input logic fs, input exp_t e);
    check({pre, ".hs"},  32'(hs),  32'(e.hs));
    check({pre, ".vs"},  32'(vs),  32'(e.vs));
    check({pre, ".x"},   32'(x),   32'(e.x));
    check({pre, ".y"},   32'(y),   32'(e.y));
    check({pre, ".rgb"}, 32'(rgb), 32'(e.rgb));
`ifdef VGA_FRAME_START_EN
    check({pre, ".fs"},  32'(fs),  32'(e.fs));
`endif
  endtask

  // All outputs sampled on the falling edge.
  always @(negedge vga_clk) begin
    if (sampling) begin
      if (!sys_rst_n) begin
        check_inst("rst_b", hs_b, vs_b, x_b, y_b, rgb_b, fs_b, '0);
        check_inst("rst_s", hs_s, vs_s, x_s, y_s, rgb_s, fs_s, '0);
        t = 0;
      end else begin
        check_inst("big", hs_b, vs_b, x_b, y_b, rgb_b, fs_b,
                   model(t, 96, 48, 640, 16, 2, 33, 480, 10, cmode_b));
        check_inst("small", hs_s, vs_s, x_s, y_s, rgb_s, fs_s,
                   model(t, SH_SYNC, SH_BACK, SH_DISP, SH_FRONT,
                         SV_SYNC, SV_BACK, SV_DISP, SV_FRONT, cmode_s));
        t++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin
    int hit_h;
    for (int i = 0; i < 256; i++) tab[i] = 16'($urandom);
    cmode_b = 1'b0;
    cmode_s = 1'($urandom_range(0, 1));

    // Power-on reset for 10 cycles.
    repeat (10) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;

    // Vsync, back porch and the first active lines of the big frame; many
    // complete small frames.
    hit_h = $urandom_range(300, 500);
    repeat (40 * 800 + hit_h) @(posedge vga_clk);

    // Mid-frame reset: counters must clear at once, without a clock edge.
    #1 sys_rst_n = 1'b0;
    #1;
    check("midrst.hs_b",  32'(hs_b),  32'd0);
    check("midrst.vs_b",  32'(vs_b),  32'd0);
    check("midrst.x_b",   32'(x_b),   32'd0);
    check("midrst.rgb_b", 32'(rgb_b), 32'd0);
    check("midrst.hs_s",  32'(hs_s),  32'd0);
    check("midrst.vs_s",  32'(vs_s),  32'd0);
    cmode_b = 1'b1;
    cmode_s = ~cmode_s;
    repeat (3) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;

    // Constant white source: blanking must still force black outside the
    // active window in both axes.
    repeat (37 * 800 + 50) @(posedge vga_clk);

    @(negedge vga_clk);
    sampling = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
